// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: datapath widths, FU classes and the
// reservation-station entry layout used by every per-FU station.
package ooo_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 5;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_MUL = 2'd2,
        FU_BR  = 2'd3
    } fu_class_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic [PREG_W-1:0] prs1;
        logic              rdy1;
        logic [PREG_W-1:0] prs2;
        logic              rdy2;
        logic [PREG_W-1:0] prd;
    } rs_entry_t;

    localparam int RS_ENTRY_W = $bits(rs_entry_t);

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority picker over a request vector.
// Latency: combinational.
// Backpressure: none; the grant simply follows the request vector.
module rs_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    always_comb begin : pick
        logic found;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/reservation_station.sv
// Age-ordered collapsing reservation station: CDB wakeup, oldest-ready issue.
// Latency: dispatch-to-issue 1 cycle when operands are ready; wake-to-issue 1 cycle.
// Backpressure: disp_ready_o from registered count only; issue holds until issue_ready_i.
module reservation_station #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = ooo_pkg::PREG_W,
    parameter int XLEN   = ooo_pkg::XLEN
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  logic [XLEN-1:0]            disp_pc_i,
    input  logic [XLEN-1:0]            disp_inst_i,
    input  logic [PREG_W-1:0]          disp_prs1_i,
    input  logic                       disp_prs1_rdy_i,
    input  logic [PREG_W-1:0]          disp_prs2_i,
    input  logic                       disp_prs2_rdy_i,
    input  logic [PREG_W-1:0]          disp_prd_i,
    input  logic                       cdb_en_i,
    input  logic [PREG_W-1:0]          cdb_reg_addr_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic [XLEN-1:0]            issue_pc_o,
    output logic [XLEN-1:0]            issue_inst_o,
    output logic [PREG_W-1:0]          issue_prs1_o,
    output logic [PREG_W-1:0]          issue_prs2_o,
    output logic [PREG_W-1:0]          issue_prd_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    import ooo_pkg::*;

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [XLEN-1:0]   pc_q   [DEPTH];
    logic [XLEN-1:0]   pc_d   [DEPTH];
    logic [XLEN-1:0]   inst_q [DEPTH];
    logic [XLEN-1:0]   inst_d [DEPTH];
    logic [PREG_W-1:0] prs1_q [DEPTH];
    logic [PREG_W-1:0] prs1_d [DEPTH];
    logic [PREG_W-1:0] prs2_q [DEPTH];
    logic [PREG_W-1:0] prs2_d [DEPTH];
    logic [PREG_W-1:0] prd_q  [DEPTH];
    logic [PREG_W-1:0] prd_d  [DEPTH];
    logic [CW-1:0]     count_q, count_d;

    logic [DEPTH-1:0]  req, gnt, wk1, wk2;
    logic [IW-1:0]     sel_idx;
    logic              sel_any, fire, accept, new_rdy1, new_rdy2;
    logic [CW-1:0]     wr_idx;

    assign disp_ready_o = (count_q < CW'(DEPTH));
    assign accept       = disp_valid_i && disp_ready_o;
    assign fire         = sel_any && issue_ready_i;
    assign wr_idx       = count_q - CW'(fire);
    assign count_o      = count_q;

    // Same-cycle CDB bypass and the hardwired-zero tag both count as ready at write.
    assign new_rdy1 = disp_prs1_rdy_i || (disp_prs1_i == '0) ||
                      (cdb_en_i && (cdb_reg_addr_i == disp_prs1_i));
    assign new_rdy2 = disp_prs2_rdy_i || (disp_prs2_i == '0) ||
                      (cdb_en_i && (cdb_reg_addr_i == disp_prs2_i));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            req[i] = valid_q[i] && rdy1_q[i] && rdy2_q[i];
            wk1[i] = rdy1_q[i] || (cdb_en_i && (prs1_q[i] == cdb_reg_addr_i));
            wk2[i] = rdy2_q[i] || (cdb_en_i && (prs2_q[i] == cdb_reg_addr_i));
        end
    end

    rs_select #(.N(DEPTH)) u_select (
        .req_i (req),
        .gnt_o (gnt),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    assign issue_valid_o = sel_any;

    always_comb begin
        issue_pc_o   = '0;
        issue_inst_o = '0;
        issue_prs1_o = '0;
        issue_prs2_o = '0;
        issue_prd_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
                issue_pc_o   = issue_pc_o   | pc_q[i];
                issue_inst_o = issue_inst_o | inst_q[i];
                issue_prs1_o = issue_prs1_o | prs1_q[i];
                issue_prs2_o = issue_prs2_o | prs2_q[i];
                issue_prd_o  = issue_prd_o  | prd_q[i];
            end
        end
    end

    // Collapse above the issued slot, carrying this cycle's wakeups along with the shift.
    always_comb begin : next_state
        logic shift;
        int   src;
        shift   = 1'b0;
        src     = 0;
        valid_d = '0;
        rdy1_d  = '0;
        rdy2_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            shift      = fire && (i >= int'(sel_idx));
            src        = (shift && (i < DEPTH-1)) ? i + 1 : i;
            valid_d[i] = (shift && (i == DEPTH-1)) ? 1'b0 : valid_q[src];
            pc_d[i]    = pc_q[src];
            inst_d[i]  = inst_q[src];
            prs1_d[i]  = prs1_q[src];
            prs2_d[i]  = prs2_q[src];
            prd_d[i]   = prd_q[src];
            rdy1_d[i]  = wk1[src];
            rdy2_d[i]  = wk2[src];
            if (accept && (wr_idx == CW'(i))) begin
                valid_d[i] = 1'b1;
                pc_d[i]    = disp_pc_i;
                inst_d[i]  = disp_inst_i;
                prs1_d[i]  = disp_prs1_i;
                prs2_d[i]  = disp_prs2_i;
                prd_d[i]   = disp_prd_i;
                rdy1_d[i]  = new_rdy1;
                rdy2_d[i]  = new_rdy2;
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
        count_d = flush_i ? '0 : (count_q + CW'(accept) - CW'(fire));
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
                prs1_q[i] <= '0;
                prs2_q[i] <= '0;
                prd_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            prs1_q  <= prs1_d;
            prs2_q  <= prs2_d;
            prd_q   <= prd_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, corner-case sequences,
// and random traffic against a queue-based reference model.
module tb_reservation_station;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        flush_i, disp_valid_i, disp_ready_o;
    logic [31:0] disp_pc_i, disp_inst_i;
    logic [4:0]  disp_prs1_i, disp_prs2_i, disp_prd_i, cdb_reg_addr_i;
    logic        disp_prs1_rdy_i, disp_prs2_rdy_i, cdb_en_i;
    logic        issue_valid_o, issue_ready_i;
    logic [31:0] issue_pc_o, issue_inst_o;
    logic [4:0]  issue_prs1_o, issue_prs2_o, issue_prd_o;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH), .PREG_W(5), .XLEN(32)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_pc_i       (disp_pc_i),
        .disp_inst_i     (disp_inst_i),
        .disp_prs1_i     (disp_prs1_i),
        .disp_prs1_rdy_i (disp_prs1_rdy_i),
        .disp_prs2_i     (disp_prs2_i),
        .disp_prs2_rdy_i (disp_prs2_rdy_i),
        .disp_prd_i      (disp_prd_i),
        .cdb_en_i        (cdb_en_i),
        .cdb_reg_addr_i  (cdb_reg_addr_i),
        .issue_valid_o   (issue_valid_o),
        .issue_ready_i   (issue_ready_i),
        .issue_pc_o      (issue_pc_o),
        .issue_inst_o    (issue_inst_o),
        .issue_prs1_o    (issue_prs1_o),
        .issue_prs2_o    (issue_prs2_o),
        .issue_prd_o     (issue_prd_o),
        .count_o         (count_o)
    );

    typedef struct {
        logic dv; logic [31:0] pc; logic [4:0] p1; logic r1; logic [4:0] p2; logic r2;
        logic [4:0] pd; logic ce; logic [4:0] ct; logic ir; logic fl;
        logic ev; logic [4:0] epd; logic [31:0] epc; logic [2:0] ecnt; logic edr;
    } vec_t;

    typedef struct {
        logic [31:0] pc, inst;
        logic [4:0]  p1, p2, pd;
        bit          r1, r2;
    } ent_t;

    vec_t tbl[13];
    ent_t mq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dv, input logic [31:0] pc, input logic [4:0] p1, input logic r1,
                         input logic [4:0] p2, input logic r2, input logic [4:0] pd,
                         input logic ce, input logic [4:0] ct, input logic ir, input logic fl);
        disp_valid_i = dv; disp_pc_i = pc; disp_inst_i = pc ^ 32'hA5A5_0000;
        disp_prs1_i = p1; disp_prs1_rdy_i = r1; disp_prs2_i = p2; disp_prs2_rdy_i = r2;
        disp_prd_i = pd; cdb_en_i = ce; cdb_reg_addr_i = ct; issue_ready_i = ir; flush_i = fl;
    endtask

    // Drive at the falling edge, then sample 1ns later, well away from the rising edge.
    task automatic step(input logic dv, input logic [31:0] pc, input logic [4:0] p1, input logic r1,
                        input logic [4:0] p2, input logic r2, input logic [4:0] pd,
                        input logic ce, input logic [4:0] ct, input logic ir, input logic fl);
        @(negedge clk);
        drive(dv, pc, p1, r1, p2, r2, pd, ce, ct, ir, fl);
        #1;
    endtask

    task automatic expect_state(input string nm, input logic ev, input logic [4:0] epd,
                                input logic [2:0] ecnt, input logic edr);
        chk({nm, ".valid"}, 128'(issue_valid_o), 128'(ev));
        chk({nm, ".prd"},   128'(issue_prd_o),   128'(epd));
        chk({nm, ".count"}, 128'(count_o),       128'(ecnt));
        chk({nm, ".drdy"},  128'(disp_ready_o),  128'(edr));
    endtask

    function automatic vec_t mk(logic dv, logic [31:0] pc, logic [4:0] p1, logic r1, logic [4:0] p2,
                                logic r2, logic [4:0] pd, logic ce, logic [4:0] ct, logic ir,
                                logic ev, logic [4:0] epd, logic [31:0] epc, logic [2:0] ecnt);
        vec_t v;
        v.dv = dv; v.pc = pc; v.p1 = p1; v.r1 = r1; v.p2 = p2; v.r2 = r2; v.pd = pd;
        v.ce = ce; v.ct = ct; v.ir = ir; v.fl = 1'b0;
        v.ev = ev; v.epd = epd; v.epc = epc; v.ecnt = ecnt; v.edr = (ecnt < 3'(DEPTH));
        return v;
    endfunction

    initial begin
        // Expected outputs per row reflect state built by the previous rows' edges.
        tbl[0]  = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0,      0);
        tbl[1]  = mk(1, 'h100,  3, 1, 0, 0, 7,  0, 0, 0,  0, 0,  0,      0);
        tbl[2]  = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,  1, 7,  'h100,  1);
        tbl[3]  = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 1,  1, 7,  'h100,  1);
        tbl[4]  = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0,      0);
        tbl[5]  = mk(1, 'h104,  5, 0, 0, 0, 10, 0, 0, 0,  0, 0,  0,      0);
        tbl[6]  = mk(1, 'h108,  6, 1, 0, 0, 11, 0, 0, 1,  0, 0,  0,      1);
        tbl[7]  = mk(0, 0,      0, 0, 0, 0, 0,  1, 5, 1,  1, 11, 'h108,  2);
        tbl[8]  = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 1,  1, 10, 'h104,  1);
        tbl[9]  = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0,      0);
        tbl[10] = mk(1, 'h10C,  0, 0, 9, 0, 12, 1, 9, 0,  0, 0,  0,      0);
        tbl[11] = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 1,  1, 12, 'h10C,  1);
        tbl[12] = mk(0, 0,      0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0,      0);

        reset_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        expect_state("reset", 0, 0, 0, 1);
        chk("reset.pc", 128'(issue_pc_o), 128'(0));
        repeat (2) @(negedge clk);
        reset_i = 1'b1;

        for (int r = 0; r < 13; r++) begin
            step(tbl[r].dv, tbl[r].pc, tbl[r].p1, tbl[r].r1, tbl[r].p2, tbl[r].r2, tbl[r].pd,
                 tbl[r].ce, tbl[r].ct, tbl[r].ir, tbl[r].fl);
            expect_state($sformatf("vec%0d", r), tbl[r].ev, tbl[r].epd, tbl[r].ecnt, tbl[r].edr);
            chk($sformatf("vec%0d.pc", r), 128'(issue_pc_o), 128'(tbl[r].epc));
        end

        // Fill to DEPTH with unready entries (prd 1..4, waiting on tags 20..23).
        for (int k = 0; k < DEPTH; k++) begin
            step(1, 32'h200 + 32'(4*k), 5'(20+k), 0, 0, 0, 5'(1+k), 0, 0, 0, 0);
            expect_state($sformatf("fill%0d", k), 0, 0, 3'(k), 1);
        end
        step(1, 'h250, 0, 1, 0, 1, 5, 0, 0, 0, 0);
        expect_state("full", 0, 0, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 22, 0, 0);
        expect_state("full_ignored", 0, 0, 4, 0);
        step(1, 'h260, 0, 1, 0, 1, 6, 0, 0, 1, 0);
        expect_state("full_fire", 1, 3, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 0);
        expect_state("no_bypass_credit", 0, 0, 3, 1);
        step(1, 'h300, 25, 0, 0, 0, 7, 0, 0, 1, 0);
        expect_state("disp_and_fire", 1, 1, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 25, 0, 0);
        expect_state("count_held", 0, 0, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 21, 0, 0);
        expect_state("new_slot_tail", 1, 7, 3, 1);
        chk("new_slot_tail.pc", 128'(issue_pc_o), 128'(32'h300));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_state("older_first", 1, 2, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_state("then_tail", 1, 7, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 23, 0, 0);
        expect_state("last_unready", 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_state("last_issue", 1, 4, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("drained", 0, 0, 0, 1);

        // Stall with one ready entry behind an unready older one.
        step(1, 'h400, 26, 0, 0, 0, 8, 0, 0, 0, 0);
        step(1, 'h404, 0, 0, 0, 0, 9, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            expect_state($sformatf("hold%0d", k), 1, 9, 2, 1);
            chk($sformatf("hold%0d.pc", k), 128'(issue_pc_o), 128'(32'h404));
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, 26, 0, 0);
        expect_state("hold_wake", 1, 9, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("older_presented", 1, 8, 2, 1);
        chk("older_presented.pc", 128'(issue_pc_o), 128'(32'h400));

        step(1, 'h408, 0, 1, 0, 1, 13, 0, 0, 0, 0);
        expect_state("pre_flush", 1, 8, 2, 1);
        step(1, 'h40C, 0, 1, 0, 1, 14, 0, 0, 1, 1);
        expect_state("flush_cycle", 1, 8, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("post_flush", 0, 0, 0, 1);

        step(1, 'h500, 0, 1, 0, 1, 15, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_state("pre_areset", 1, 15, 1, 1);
        #2 reset_i = 1'b0;
        #1;
        expect_state("areset", 0, 0, 0, 1);
        chk("areset.pc", 128'(issue_pc_o), 128'(0));
        @(negedge clk);
        reset_i = 1'b1;

        // Random traffic against the queue model; small tag space forces frequent wakeups.
        mq.delete();
        for (int c = 0; c < 1500; c++) begin
            logic        dv, r1, r2, ce, ir, fl, ev, fire, acc;
            logic [4:0]  p1, p2, pd, ct;
            logic [31:0] pc;
            logic [94:0] exp_iss;
            int          sel;
            dv = ($urandom_range(0, 99) < 60); r1 = ($urandom_range(0, 99) < 30);
            r2 = ($urandom_range(0, 99) < 30); ce = ($urandom_range(0, 1) == 1);
            ir = ($urandom_range(0, 99) < 55); fl = ($urandom_range(0, 99) < 2);
            p1 = 5'($urandom_range(0, 7)); p2 = 5'($urandom_range(0, 7));
            pd = 5'($urandom_range(0, 31)); ct = 5'($urandom_range(0, 7));
            pc = $urandom;
            step(dv, pc, p1, r1, p2, r2, pd, ce, ct, ir, fl);

            sel = -1;
            foreach (mq[k]) if (sel < 0 && mq[k].r1 && mq[k].r2) sel = k;
            ev = (sel >= 0);
            exp_iss = '0;
            if (ev) exp_iss = {1'b1, mq[sel].pc, mq[sel].inst, mq[sel].p1, mq[sel].p2, mq[sel].pd};
            chk("rand.issue", 128'({issue_valid_o, issue_pc_o, issue_inst_o, issue_prs1_o,
                                    issue_prs2_o, issue_prd_o}), 128'(exp_iss));
            chk("rand.count", 128'(count_o), 128'(mq.size()));
            chk("rand.drdy", 128'(disp_ready_o), 128'(mq.size() < DEPTH));

            if (fl) begin
                mq.delete();
            end else begin
                fire = ev && ir;
                acc  = dv && (mq.size() < DEPTH);
                if (fire) mq.delete(sel);
                foreach (mq[k]) begin
                    if (ce && mq[k].p1 == ct) mq[k].r1 = 1;
                    if (ce && mq[k].p2 == ct) mq[k].r2 = 1;
                end
                if (acc) begin
                    ent_t e;
                    e.pc = pc; e.inst = pc ^ 32'hA5A5_0000; e.p1 = p1; e.p2 = p2; e.pd = pd;
                    e.r1 = r1 || (p1 == 0) || (ce && ct == p1);
                    e.r2 = r2 || (p2 == 0) || (ce && ct == p2);
                    mq.push_back(e);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
